// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// bit-counter width and the controller state encoding.
package div_pkg;

    localparam int DIVIDEND_W = 12;
    localparam int DIVISOR_W  = 5;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the incoming dividend bit
// into the partial remainder, then subtract the divisor if it fits.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_part,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_part,
    output logic                 o_qbit
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W+1:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in DIVISOR_W+1 bits; the extra top bit keeps the compare exact.
    always_comb begin
        w_shift = {i_part, i_bit};
        w_diff  = w_shift - {2'b00, i_divisor};
        o_qbit  = (w_shift >= {2'b00, i_divisor});
        o_part  = o_qbit ? w_diff[DIVISOR_W:0] : w_shift[DIVISOR_W:0];
    end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock, behind a
// start/busy/done handshake.
// Optional feature macro: DIV_ZERO_FAST_EN -- a zero divisor skips the
// iterations and finishes in the cycle after acceptance with div_by_zero set.
module sequential_divider
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_t                r_state;
    state_t                w_nextState;
    logic [DIVIDEND_W-1:0] r_shift;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W:0]    r_part;
    logic [CNT_W-1:0]      r_count;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W:0]    w_nextPart;
    logic                  w_qbit;

    div_step u_step (
        .i_part    (r_part),
        .i_bit     (r_shift[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_part    (w_nextPart),
        .o_qbit    (w_qbit)
    );

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state and handshake outputs; start is only looked at in IDLE.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    w_nextState = (divisor == '0) ? DONE : RUN;
`else
                    w_nextState = RUN;
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_count == '0) w_nextState = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, and result
    // registers loaded on the edge into DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_divisor <= '0;
            r_part    <= '0;
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_part    <= '0;
                        r_count   <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            r_quot <= '1;
                            r_rem  <= '0;
                        end
`endif
                    end
                end
                RUN: begin
                    r_shift <= {r_shift[DIVIDEND_W-2:0], w_qbit};
                    r_part  <= w_nextPart;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == '0) begin
                        r_quot <= {r_shift[DIVIDEND_W-2:0], w_qbit};
                        r_rem  <= w_nextPart[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_FAST_EN
    logic r_dbz;

    // Divide-by-zero flag, loaded only on the fast zero-divisor path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else if (r_state == IDLE && start) begin
            if (divisor == '0) r_dbz <= 1'b1;
        end else if (r_state == RUN && r_count == '0) begin
            r_dbz <= 1'b0;
        end
    end

    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule
